plab4_net_router_output_sched: RTL

Per-output-port scheduler for a ring router. It shares one router output channel (west, terminal or east) among the three input controllers that raise one-hot requests toward it. Arbitration is round-robin. It tracks credits for the downstream input queue and exports the `num_free` count that the input controllers compare against their `p_num_free_nbits` threshold. One instance sits beside each output mux; `grants` drive both the mux select and the input controllers' `grants` inputs.

---
 rtl/plab4_net_router_output_sched.sv | 110 +++++++++++
 1 files changed

// File: rtl/plab4_net_router_output_sched.sv
// Round-robin scheduler for one ring-router output channel with downstream credit tracking.
// Credit state is built only when PLAB4_NET_SCHED_CREDIT_EN is defined.
`default_nettype none

module plab4_net_router_output_sched #(
   parameter int p_num_credits    = 3,
   parameter int p_num_free_nbits = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [2:0]                  reqs,
   output logic [2:0]                  grants,
   output logic                        out_val,
   input  logic                        out_rdy,
   input  logic                        credit_ret,
   output logic [p_num_free_nbits-1:0] num_free,
   output logic                        credit_err
);

   localparam logic [p_num_free_nbits-1:0] c_num_credits = p_num_free_nbits'(p_num_credits);
   localparam logic [p_num_free_nbits-1:0] c_one         = p_num_free_nbits'(1);

   logic [2:0] prio_q;
   logic [2:0] prio_d;
   logic       can_send;
   logic       fire;

`ifdef PLAB4_NET_SCHED_CREDIT_EN
   logic [p_num_free_nbits-1:0] credit_cnt_q;
   logic [p_num_free_nbits-1:0] credit_cnt_d;
   logic                        credit_err_q;
   logic                        credit_err_d;

   assign can_send = out_rdy & (credit_cnt_q != '0);

   // A send and a return in the same cycle cancel out.
   always_comb begin
      credit_cnt_d = credit_cnt_q;
      credit_err_d = credit_err_q;
      if (fire && !credit_ret) begin
         credit_cnt_d = credit_cnt_q - c_one;
      end else if (!fire && credit_ret) begin
         if (credit_cnt_q < c_num_credits) begin
            credit_cnt_d = credit_cnt_q + c_one;
         end else begin
            credit_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         credit_cnt_q <= c_num_credits;
         credit_err_q <= 1'b0;
      end else begin
         credit_cnt_q <= credit_cnt_d;
         credit_err_q <= credit_err_d;
      end
   end

   assign num_free   = credit_cnt_q;
   assign credit_err = credit_err_q;
`else
   logic unused_credit_ret;
   assign unused_credit_ret = credit_ret;

   assign can_send   = out_rdy;
   assign num_free   = c_num_credits;
   assign credit_err = 1'b0;
`endif

   // Search starts at the pointer bit and wraps upward.
   always_comb begin
      grants = 3'b000;
      if (can_send) begin
         case (prio_q)
            3'b010: begin
               if      (reqs[1]) grants = 3'b010;
               else if (reqs[2]) grants = 3'b100;
               else if (reqs[0]) grants = 3'b001;
            end
            3'b100: begin
               if      (reqs[2]) grants = 3'b100;
               else if (reqs[0]) grants = 3'b001;
               else if (reqs[1]) grants = 3'b010;
            end
            default: begin
               if      (reqs[0]) grants = 3'b001;
               else if (reqs[1]) grants = 3'b010;
               else if (reqs[2]) grants = 3'b100;
            end
         endcase
      end
   end

   assign out_val = |grants;
   assign fire    = out_val;
   assign prio_d  = fire ? {grants[1:0], grants[2]} : prio_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_q <= 3'b001;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

`default_nettype wire
